// File: rtl/datamem_arbiter.sv
// datamem_arbiter: shares a single-port data memory between the CPU
// execute-stage load/store port and a DMA/debug requester. The CPU has
// priority; a saturating wait counter force-grants a DMA request after it
// has lost MAX_WAIT consecutive cycles, so the DMA port can never starve.
module datamem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,       // asynchronous, active-low
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Which requester owns the read data returning from memory this cycle.
  typedef struct packed {
    logic cpu;
    logic dma;
  } rd_owner_t;

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  rd_owner_t         rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_wdata_q;

  logic cpu_act;
  logic force_grant;
  logic dma_win;
  logic cpu_win;

  // Grant decision; reset gates both winners so every output drops at once.
  always_comb begin
    cpu_act     = cpu_we | cpu_re;
    force_grant = dma_req && (wait_cnt_q == MAX_CNT);
    dma_win     = reset && dma_req && (!cpu_act || force_grant);
    cpu_win     = reset && cpu_act && !dma_win;
  end

  // Memory-side mux and requester handshakes driven by the winner.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    if (!reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (dma_win) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      mem_re    = ~dma_we;
      dma_gnt   = 1'b1;
      cpu_stall = cpu_act;
    end else if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = cpu_re & ~cpu_we;   // simultaneous we/re is a write
    end
  end

  // Next state for the starvation counter and the read-data owner.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dma_req || dma_win) begin
      wait_cnt_d = '0;
    end else if (cpu_win && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    rd_owner_d.cpu = cpu_win & ~cpu_we;
    rd_owner_d.dma = dma_win & ~dma_we;
  end

  // State registers; the last driven address/data are held while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      rd_owner_q   <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
      if (dma_win || cpu_win) begin
        last_addr_q  <= mem_addr;
        last_wdata_q <= mem_wdata;
      end
    end
  end

  // Read data routed to whichever requester issued the read last cycle.
  always_comb begin
    dma_rvalid = rd_owner_q.dma;
    dma_rdata  = rd_owner_q.dma ? mem_rdata : '0;
    cpu_rdata  = rd_owner_q.cpu ? mem_rdata : '0;
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port data memory between the CPU core's execute-stage load/store port and a secondary DMA/debug requester.
- Muxes address, write data and enables to the memory, and routes read data back to the right requester.
- Stalls the CPU when it loses arbitration.
- Priority goes to the CPU, with a bounded-wait counter so the DMA port can never starve.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory.
- DATA_W, 16, data width.
- MAX_WAIT, 4, number of consecutive cycles a pending DMA request may lose to the CPU before it is force-granted. A value of 0 gives the DMA strict priority.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  CPU access address (ALU result).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_we  in  1  CPU store request.
- cpu_re  in  1  CPU load request.
- cpu_stall  out  1  CPU access not performed this cycle; the CPU must hold its request.
- cpu_rdata  out  DATA_W  load data, valid the cycle after a granted CPU read.
- dma_req  in  1  DMA access request; held until granted.
- dma_we  in  1  1 means write, 0 means read; qualified by dma_req.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  dma_rdata valid; asserted the cycle after a granted DMA read.
- dma_rdata  out  DATA_W  DMA read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_re.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; all are combinationally low while reset is asserted:
  - wait_cnt, rd_owner and dma_rvalid to 0.
  - cpu_stall, dma_gnt, mem_we and mem_re to 0.
  - mem_addr and mem_wdata to 0.
- cpu_act = cpu_we | cpu_re. If both are set, the access is a write: mem_re=0.
- Grant decision is combinational, made every cycle:
  - force = dma_req & (wait_cnt == MAX_WAIT).
  - dma_win = dma_req & (~cpu_act | force).
  - cpu_win = cpu_act & ~dma_win.
- Outputs by winner:
  - dma_win: dma_gnt=1; memory signals come from the DMA port; mem_we=dma_we; mem_re=~dma_we; cpu_stall=cpu_act.
  - cpu_win: memory signals come from the CPU port; cpu_stall=0.
  - Neither wins: mem_we=0, mem_re=0; mem_addr and mem_wdata hold their last driven values.
- wait_cnt is registered and saturates at MAX_WAIT:
  - It increments on a cycle where dma_req=1 and cpu_win=1.
  - It clears on dma_gnt or when dma_req=0.
- Latency: an uncontended access adds 0 cycles. Read data returns 1 cycle after the grant, matching the memory.
- rd_owner is a registered 2-bit value: bit CPU = cpu_win & ~cpu_we; bit DMA = dma_win & ~dma_we.
  - dma_rvalid = registered rd_owner.DMA.
  - dma_rdata = mem_rdata when dma_rvalid=1, else 0.
  - cpu_rdata = mem_rdata when rd_owner.CPU=1, else 0.
- Back-to-back: a read granted in cycle N returns in N+1 while a new access is granted in N+1. Both are allowed, with no turnaround bubble.
- Sustained contention: the DMA gets 1 grant per MAX_WAIT+1 cycles; the CPU gets the other MAX_WAIT.
- MAX_WAIT=0: force=dma_req, so the DMA always wins.
- Reset asserted mid-read: the pending rvalid is discarded and no read data is delivered after release.
- dma_we is ignored while dma_req=0.

Test Plan:
- Reset check: hold reset=0 with cpu_re=1 and dma_req=1 → all outputs 0. Release reset, cpu_we=1, addr=0x0010, wdata=0xBEEF, no DMA → mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF, cpu_stall=0 in the same cycle.
- CPU idle, DMA read of 0x0020 (memory holds 0x1234) → dma_gnt=1 and mem_re=1 in cycle N; dma_rvalid=1 and dma_rdata=0x1234 in N+1; cpu_rdata=0.
- Starvation with MAX_WAIT=4: cpu_re held every cycle and dma_req held with a write → cpu_stall=0 for 4 cycles, then dma_gnt=1 and cpu_stall=1 in cycle 5; repeating period of 5; wait_cnt never exceeds 4.
- CPU with cpu_we=1 and cpu_re=1 to 0x0030 → write only: mem_we=1, mem_re=0, no cpu_rdata return the next cycle.
- Interleaved reads: CPU read 0x0001 (data 0xAAAA) in N, DMA read 0x0002 (data 0x5555) in N+1 with the CPU idle → cpu_rdata=0xAAAA in N+1, dma_rvalid=1 with 0x5555 in N+2.
- DMA read granted, then reset=0 asserted before the next edge → dma_rvalid stays 0 through and after reset release.
